// File: rtl/proc_elem_pkg.sv
// Shared definitions for the processing element's FP16 datapath (multiplier and adder).
package proc_elem_pkg;

    localparam int unsigned EXP_W  = 5;
    localparam int unsigned FRAC_W = 10;
    localparam int unsigned BIAS   = 15;

    // Implicit-bit mantissa, full product, and signed exponent-sum widths
    localparam int unsigned MANT_W = FRAC_W + 1;
    localparam int unsigned PROD_W = 2 * MANT_W;
    localparam int unsigned ESUM_W = 7;

    localparam logic [15:0]      FP16_QNAN     = 16'h7E00;
    localparam logic [15:0]      FP16_POS_ZERO = 16'h0000;
    localparam logic [EXP_W-1:0] EXP_MAX       = 5'h1F;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

    // Special-case outcome resolved in S1 and carried down the pipe
    typedef enum logic [1:0] {RkNone, RkQnan, RkInf, RkZero} res_kind_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational FP16 unpacker: operand class plus implicit-bit mantissa.
// Subnormals are flushed to zero, so the implicit bit is always 1.
module fp16_classify
    import proc_elem_pkg::*;
(
    input  fp16_t             i_op,
    output fp_class_t         o_class,
    output logic [MANT_W-1:0] o_mant
);

    logic w_unused_sign;
    assign w_unused_sign = i_op.sign;

    assign o_mant = {1'b1, i_op.frac};

    // Classify by exponent field; frac only distinguishes inf from nan
    always_comb begin
        o_class = NORM;
        if (i_op.exp == '0) begin
            o_class = ZERO;
        end else if (i_op.exp == EXP_MAX) begin
            o_class = (i_op.frac == '0) ? INF : NAN;
        end
    end

endmodule

// File: rtl/fp16_mult_pipe.sv
// Three-stage FP16 multiplier (unpack / multiply / normalize-pack) with valid/ready
// handshake on both sides. Truncating rounding, subnormals flushed to zero.
module fp16_mult_pipe
    import proc_elem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] m_p
);

    localparam logic signed [ESUM_W-1:0] ExpSat = ESUM_W'(EXP_MAX);
    localparam logic signed [ESUM_W-1:0] ExpOne = 1;

    fp16_t             w_a, w_b;
    fp_class_t         w_cls_a, w_cls_b;
    logic [MANT_W-1:0] w_mant_a, w_mant_b;

    assign w_a = a;
    assign w_b = b;

    fp16_classify u_cls_a (
        .i_op    (w_a),
        .o_class (w_cls_a),
        .o_mant  (w_mant_a)
    );

    fp16_classify u_cls_b (
        .i_op    (w_b),
        .o_class (w_cls_b),
        .o_mant  (w_mant_b)
    );

    // Pipeline registers
    logic                     r_s1_valid, r_s2_valid, r_s3_valid;
    logic                     r_s1_sign, r_s2_sign;
    logic signed [ESUM_W-1:0] r_s1_exp, r_s2_exp;
    logic [MANT_W-1:0]        r_s1_ma, r_s1_mb;
    logic [PROD_W-1:0]        r_s2_prod;
    res_kind_t                r_s1_kind, r_s2_kind;
    logic [15:0]              r_m_p;

    // Handshake wires
    logic w_s3_ready, w_s2_adv, w_s2_ready, w_s1_adv, w_in_fire;

    // Back-pressure chain from the output; in_ready never depends on in_valid
    always_comb begin
        w_s3_ready = ~r_s3_valid | out_ready;
        w_s2_adv   = r_s2_valid & w_s3_ready;
        w_s2_ready = ~r_s2_valid | w_s2_adv;
        w_s1_adv   = r_s1_valid & w_s2_ready;
        in_ready   = ~r_s1_valid | w_s1_adv;
        w_in_fire  = in_valid & in_ready;
    end

    // S1 combinational: sign, biased exponent sum and special-case resolution
    logic                     w_s1_sign;
    logic signed [ESUM_W-1:0] w_s1_exp;
    res_kind_t                w_s1_kind;

    always_comb begin
        w_s1_sign = w_a.sign ^ w_b.sign;
        w_s1_exp  = ESUM_W'(w_a.exp) + ESUM_W'(w_b.exp) - ESUM_W'(BIAS);
        w_s1_kind = RkNone;
        if (w_cls_a == NAN || w_cls_b == NAN ||
            (w_cls_a == INF && w_cls_b == ZERO) ||
            (w_cls_a == ZERO && w_cls_b == INF)) begin
            w_s1_kind = RkQnan;
        end else if (w_cls_a == INF || w_cls_b == INF) begin
            w_s1_kind = RkInf;
        end else if (w_cls_a == ZERO || w_cls_b == ZERO) begin
            w_s1_kind = RkZero;
        end
    end

    // S1 register: load when empty or when the current contents move to S2
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else begin
            if (in_ready) r_s1_valid <= in_valid;
            if (w_in_fire) begin
                r_s1_sign <= w_s1_sign;
                r_s1_exp  <= w_s1_exp;
                r_s1_ma   <= w_mant_a;
                r_s1_mb   <= w_mant_b;
                r_s1_kind <= w_s1_kind;
            end
        end
    end

    // S2 register: full 11x11 mantissa product
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s2_ready) r_s2_valid <= r_s1_valid;
            if (w_s1_adv) begin
                r_s2_sign <= r_s1_sign;
                r_s2_exp  <= r_s1_exp;
                r_s2_prod <= PROD_W'(r_s1_ma) * PROD_W'(r_s1_mb);
                r_s2_kind <= r_s1_kind;
            end
        end
    end

    // S3 combinational: normalize by at most one place, truncate, pack
    logic                     w_norm_hi;
    logic signed [ESUM_W-1:0] w_s3_exp;
    logic [FRAC_W-1:0]        w_s3_frac;
    fp16_t                    w_s3_res;
    logic                     w_unused_prod;

    assign w_unused_prod = ^r_s2_prod[FRAC_W-1:0];

    always_comb begin
        w_norm_hi = r_s2_prod[PROD_W-1];
        w_s3_exp  = r_s2_exp + ESUM_W'(w_norm_hi);
        w_s3_frac = w_norm_hi ? r_s2_prod[PROD_W-2:MANT_W] : r_s2_prod[PROD_W-3:FRAC_W];
        w_s3_res  = FP16_POS_ZERO;
        unique case (r_s2_kind)
            RkQnan: w_s3_res = FP16_QNAN;
            RkInf: begin
                w_s3_res.sign = r_s2_sign;
                w_s3_res.exp  = EXP_MAX;
            end
            RkZero: w_s3_res = FP16_POS_ZERO;
            RkNone: begin
                if (w_s3_exp >= ExpSat) begin
                    w_s3_res.sign = r_s2_sign;
                    w_s3_res.exp  = EXP_MAX;
                end else if (w_s3_exp >= ExpOne) begin
                    w_s3_res.sign = r_s2_sign;
                    w_s3_res.exp  = w_s3_exp[EXP_W-1:0];
                    w_s3_res.frac = w_s3_frac;
                end
            end
        endcase
    end

    // S3 register: m_p changes only when a new product is loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_valid <= 1'b0;
            r_m_p      <= FP16_POS_ZERO;
        end else begin
            if (w_s3_ready) r_s3_valid <= r_s2_valid;
            if (w_s2_adv) r_m_p <= w_s3_res;
        end
    end

    assign out_valid = r_s3_valid;
    assign m_p       = r_m_p;

endmodule

// File: tb/tb_fp16_mult_pipe.sv
// Self-checking bench for fp16_mult_pipe: directed values, streaming, backpressure,
// mid-stream reset and randomized traffic against a real-arithmetic reference model.
`timescale 1ns/1ps
module tb_fp16_mult_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] m_p;

    logic ready_req = 1'b1;
    logic rnd_bp    = 1'b0;
    logic rnd_rdy   = 1'b1;
    assign out_ready = rnd_bp ? rnd_rdy : ready_req;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          n_out    = 0;
    bit          lat_en   = 1'b0;
    logic [15:0] cur_exp;
    logic [15:0] exp_q[$];
    int          acc_q[$];

    fp16_mult_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .m_p       (m_p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: value-level product in real arithmetic, then re-encode with truncation
    function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        int   ex, ey, fx, fy, ue, e, fr;
        bit   s, zx, zy, ix, iy, nx, ny;
        real  q;
        ex = int'(x[14:10]); ey = int'(y[14:10]);
        fx = int'(x[9:0]);   fy = int'(y[9:0]);
        s  = x[15] ^ y[15];
        zx = (ex == 0);  zy = (ey == 0);
        ix = (ex == 31) && (fx == 0); iy = (ey == 31) && (fy == 0);
        nx = (ex == 31) && (fx != 0); ny = (ey == 31) && (fy != 0);
        if (nx || ny || (ix && zy) || (iy && zx)) return 16'h7E00;
        if (ix || iy) return {s, 15'h7C00};
        if (zx || zy) return 16'h0000;
        q  = (1.0 + fx / 1024.0) * (1.0 + fy / 1024.0);
        ue = (ex - 15) + (ey - 15);
        if (q >= 2.0) begin
            q  = q / 2.0;
            ue = ue + 1;
        end
        e = ue + 15;
        if (e >= 31) return {s, 15'h7C00};
        if (e <= 0) return 16'h0000;
        fr = $rtoi((q - 1.0) * 1024.0);
        return {s, 5'(e), 10'(fr)};
    endfunction

    // Scoreboard: record accepts, match every retired product in order
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                check_eq("out_has_expect", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check_eq("m_p", 32'(m_p), 32'(exp_q.pop_front()));
                    if (lat_en) check_eq("latency", 32'(cyc - acc_q[0]), 32'd3);
                    void'(acc_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
                acc_q.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] e);
        int t;
        @(posedge clk); #1;
        a = x; b = y; cur_exp = e; in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [15:0] dir_a[10] = '{16'h3C00, 16'h4000, 16'h3E00, 16'hC000, 16'h3C01,
                               16'h7800, 16'h0400, 16'h7C00, 16'h7C00, 16'h8000};
    logic [15:0] dir_b[10] = '{16'h3C00, 16'h4200, 16'h3E00, 16'h4200, 16'h3C01,
                               16'h4000, 16'h0400, 16'h0000, 16'hC000, 16'h4000};
    logic [15:0] dir_e[10] = '{16'h3C00, 16'h4600, 16'h4080, 16'hC600, 16'h3C02,
                               16'h7C00, 16'h0000, 16'h7E00, 16'hFC00, 16'h0000};
    logic [15:0] pa[5], pb[5];

    initial begin
        int idx, n0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cur_exp = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_m_p", 32'(m_p), 32'h0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed values, one at a time, unstalled
        lat_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(dir_a[i], dir_b[i], dir_e[i]);
            idle();
            drain();
        end

        // Back-to-back stream of 8
        for (int i = 0; i < 8; i++) begin
            logic [15:0] x, y;
            x = 16'($urandom);
            y = 16'($urandom);
            send(x, y, ref_mul(x, y));
        end
        idle();
        drain();

        // Backpressure: 5 offered with out_ready low, only 3 fit
        lat_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pa[i] = 16'h3C00 + 16'(i * 16'h0101);
            pb[i] = 16'h4100 + 16'(i * 16'h0033);
        end
        ready_req = 1'b0;
        n0 = n_out;
        idx = 0;
        @(posedge clk); #1;
        a = pa[0]; b = pb[0]; cur_exp = ref_mul(pa[0], pb[0]); in_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk); #1;
            if (idx < 5) begin
                a = pa[idx]; b = pb[idx]; cur_exp = ref_mul(pa[idx], pb[idx]);
            end
        end
        @(negedge clk);
        check_eq("bp_accepts", 32'(idx), 32'd3);
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_out_valid", 32'(out_valid), 32'd1);
        check_eq("bp_hold0", 32'(m_p), 32'(ref_mul(pa[0], pb[0])));
        repeat (2) @(negedge clk);
        check_eq("bp_hold1", 32'(m_p), 32'(ref_mul(pa[0], pb[0])));
        check_eq("bp_no_retire", 32'(n_out - n0), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        ready_req = 1'b1;
        send(pa[3], pb[3], ref_mul(pa[3], pb[3]));
        send(pa[4], pb[4], ref_mul(pa[4], pb[4]));
        idle();
        drain();
        repeat (3) @(negedge clk);
        check_eq("bp_retired", 32'(n_out - n0), 32'd5);

        // Reset with three operations in flight
        ready_req = 1'b0;
        send(16'h4000, 16'h4200, ref_mul(16'h4000, 16'h4200));
        send(16'h3E00, 16'h4400, ref_mul(16'h3E00, 16'h4400));
        send(16'hC200, 16'h3800, ref_mul(16'hC200, 16'h3800));
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ready_req = 1'b1;
        n0 = n_out;
        @(negedge clk);
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_m_p", 32'(m_p), 32'h0);
        repeat (6) @(negedge clk);
        check_eq("mid_rst_no_output", 32'(n_out - n0), 32'd0);
        lat_en = 1'b1;
        send(16'h4000, 16'h4000, 16'h4400);
        idle();
        drain();

        // Randomized traffic with random output stalls
        lat_en = 1'b0;
        rnd_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [15:0] x, y;
            x = 16'($urandom);
            y = 16'($urandom);
            if ($urandom_range(0, 3) == 0) idle();
            send(x, y, ref_mul(x, y));
        end
        idle();
        rnd_bp = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fp16_mult_pipe.md
Name: fp16_mult_pipe

Overview:
- Pipelined IEEE-754 binary16 multiplier inside the processing element.
- Produces the multiplier product operand (m_p) consumed directly by the PE's FP16 adder, which sums it with the running partial sum (p_s).
- Three register stages with valid/ready handshake on both sides; full throughput of one product per cycle when unstalled.

Parameters:
- EXP_W, 5, exponent field width.
- FRAC_W, 10, fraction field width.
- BIAS, 15, exponent bias.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair a/b valid.
- in_ready  out  1  stage 1 can accept the operand pair this cycle.
- a  in  16  operand A {sign, exp, frac}.
- b  in  16  operand B {sign, exp, frac}.
- out_valid  out  1  m_p holds a valid product.
- out_ready  in  1  downstream adder consumes m_p this cycle.
- m_p  out  16  product {sign, exp, frac}.

Behaviour:
- Reset: all stage valid bits = 0; out_valid = 0; m_p = 16'h0000; in_ready = 1 on the first cycle after reset deasserts.
- Handshake: a transfer occurs when valid && ready is high at the rising edge. m_p and out_valid hold stable while out_valid=1 and out_ready=0.
- Pipeline: S1 -> S2 -> S3, where S3 drives m_p. Stage k loads when it is empty or when its contents advance in the same cycle. in_ready = ~s1_valid | s1_adv, with s3_adv = out_ready and no combinational path from in_valid to in_ready.
- Latency: 3 cycles from the input transfer to out_valid; throughput 1/cycle.
- S1 (unpack):
  - sign = sa ^ sb.
  - Classify each operand as zero (exp=0, any frac; subnormals flush to zero), inf (exp=31, frac=0) or nan (exp=31, frac!=0).
  - Mantissas: {1, frac}, 11 bits each.
  - Exponent sum: ea + eb - BIAS, carried as a 7-bit signed value.
- S2 (multiply): P = ma * mb, 22-bit unsigned.
- S3 (normalize/pack):
  - If P[21]=1: frac = P[20:11], e = e + 1.
  - Otherwise: frac = P[19:10].
  - Rounding is truncation (round toward zero), consistent with the PE adder.
- Special results, in priority order:
  - Any nan, or inf*zero -> 16'h7E00.
  - inf*finite or inf*inf -> {sign, 5'h1F, 10'h0}.
  - Any zero operand -> 16'h0000 (sign cleared).
  - Post-normalize e >= 31 -> {sign, 5'h1F, 10'h0}.
  - Post-normalize e <= 0 -> 16'h0000.
- Bubbles: empty stages carry no data. m_p updates only when S3 loads.
- Simultaneous events: a full pipe with out_ready=1 and in_valid=1 accepts the new pair and retires the oldest in the same cycle; no loss, no duplication.
- Reset mid-operation: every in-flight operation is discarded, out_valid falls the cycle after rst is sampled, and no partial product emerges afterwards.

Decomposition:
- Shared package proc_elem_pkg holds:
  - Field widths and BIAS.
  - FP16_QNAN = 16'h7E00, FP16_POS_ZERO = 16'h0000, EXP_MAX = 5'h1F.
  - fp16_t packed struct {sign, exp, frac}.
  - fp_class_t enum {ZERO, NORM, INF, NAN}. The adder uses the same package.
- One natural sub-module: fp16_classify, a combinational unpacker (class, implicit-bit mantissa). It is instantiated twice in S1 and can be reused by the adder.

Test Plan:
- Basic values, out_ready held at 1:
  - 3C00*3C00 -> 3C00.
  - 4000*4200 -> 4600.
  - 3E00*3E00 -> 4080.
  - C000*4200 -> C600.
  - Each appears exactly 3 cycles after the accept.
- Truncation: 3C01*3C01 -> 3C02.
- Specials and range limits:
  - 7800*4000 -> 7C00 (overflow).
  - 0400*0400 -> 0000 (underflow).
  - 7C00*0000 -> 7E00.
  - 7C00*C000 -> FC00.
  - 8000*4000 -> 0000.
- Back-to-back stream: 8 pairs in consecutive cycles with out_ready=1 -> 8 consecutive out_valid cycles, results in order.
- Backpressure:
  - Stream 5 pairs with out_ready=0 -> in_ready drops after 3 accepts.
  - m_p holds the first result stable.
  - Raising out_ready drains all 5 in order, with no drops or duplicates.
- Reset mid-stream: assert rst for 1 cycle with 3 operations in flight -> out_valid=0 and m_p=0000 the next cycle, none of the 3 results appear, and a new 4000*4000 yields 4400 after 3 cycles.
